serial_tx_handshake: RTL and testbench

//  Parallel-to-serial transmitter: accepts an N-bit word from a producer via the dav_/rfd handshake,

---
 rtl/serial_tx_handshake.sv | 110 +++++++++++
 tb/tb_serial_tx_handshake.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/serial_tx_handshake.sv
// Parallel-to-serial transmitter: captures a word on the dav_/rfd handshake and
// sends it as start(0), N data bits LSB-first, stop(1). All outputs are registered.
module serial_tx_handshake #(
    parameter int N          = 8,
    parameter int BIT_CYCLES = 4
) (
    input  logic         clock,
    input  logic         reset_,
    input  logic         dav_,
    input  logic [N-1:0] byte_in,
    output logic         rfd,
    output logic         out
);

    localparam int TW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    localparam logic [2:0] S_WAIT  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_STOP  = 3'd3;
    localparam logic [2:0] S_HS    = 3'd4;

    localparam logic [TW-1:0] TICK_LAST = TW'(BIT_CYCLES - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(N - 1);

    logic [2:0]    state;
    logic [TW-1:0] tick;
    logic [IW-1:0] idx;
    logic [IW-1:0] idx_nx;
    logic [N-1:0]  buffer;
    logic          tick_last;

    assign idx_nx    = idx + 1'b1;
    assign tick_last = (tick == TICK_LAST);

    always_ff @(posedge clock or negedge reset_) begin
        if (!reset_) begin
            state  <= S_WAIT;
            rfd    <= 1'b1;
            out    <= 1'b1;
            tick   <= '0;
            idx    <= '0;
            buffer <= '0;
        end else begin
            case (state)
                S_WAIT: begin
                    if (!dav_) begin
                        buffer <= byte_in;
                        rfd    <= 1'b0;
                        out    <= 1'b0;
                        tick   <= '0;
                        state  <= S_START;
                    end
                end
                S_START: begin
                    if (tick_last) begin
                        tick  <= '0;
                        out   <= buffer[0];
                        idx   <= '0;
                        state <= S_DATA;
                    end else begin
                        tick <= tick + 1'b1;
                    end
                end
                S_DATA: begin
                    if (tick_last) begin
                        tick <= '0;
                        if (idx != IDX_LAST) begin
                            idx <= idx_nx;
                            out <= buffer[idx_nx];
                        end else begin
                            out   <= 1'b1;
                            state <= S_STOP;
                        end
                    end else begin
                        tick <= tick + 1'b1;
                    end
                end
                S_STOP: begin
                    // Producer still holding dav_ low must release it before rfd returns.
                    if (tick_last) begin
                        tick <= '0;
                        if (dav_) begin
                            rfd   <= 1'b1;
                            state <= S_WAIT;
                        end else begin
                            state <= S_HS;
                        end
                    end else begin
                        tick <= tick + 1'b1;
                    end
                end
                S_HS: begin
                    if (dav_) begin
                        rfd   <= 1'b1;
                        state <= S_WAIT;
                    end
                end
                default: begin
                    state <= S_WAIT;
                    rfd   <= 1'b1;
                    out   <= 1'b1;
                    tick  <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_tx_handshake.sv
// Bench for serial_tx_handshake: reset behaviour, a table of directed frames,
// reset-abort sequences and randomized frames against a cycle-indexed frame model.
module tb_serial_tx_handshake;

    localparam int N  = 8;
    localparam int BC = 4;
    localparam int FL = (N + 2) * BC;

    logic         clock = 1'b0;
    logic         reset_;
    logic         dav_;
    logic [N-1:0] byte_in;
    logic         rfd;
    logic         out;

    int n_checks = 0;
    int n_fail   = 0;

    serial_tx_handshake #(.N(N), .BIT_CYCLES(BC)) dut (
        .clock  (clock),
        .reset_ (reset_),
        .dav_   (dav_),
        .byte_in(byte_in),
        .rfd    (rfd),
        .out    (out)
    );

    always #5 clock = ~clock;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
        $fatal(1);
    end

    typedef struct {
        logic [N-1:0] data;
        int           hold;      // dav_ sampled low on edges E0..E0+hold-1
        bit           scramble;  // drive byte_in=0 after capture
        logic [N+1:0] frame;     // line bit i (start=bit0, stop=bit N+1)
        int           rfd_k;     // edge offset where rfd returns to 1
    } vec_t;

    task automatic check(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cycle();
        @(posedge clock);
        #1;
    endtask

    // Line bit number k/BC of the frame is expected for BC clocks each.
    task automatic run_frame(input logic [N-1:0] data, input int hold, input bit scramble,
                             input logic [N+1:0] frame, input int rfd_k, input int stop_k,
                             input string tag);
        int w;
        w = 0;
        while (rfd !== 1'b1 && w < 100) begin
            cycle();
            w++;
        end
        check({tag, " ready"}, rfd, 1'b1);
        byte_in = data;
        dav_    = 1'b0;
        for (int k = 0; k <= stop_k && k <= rfd_k; k++) begin
            cycle();
            check({tag, " out"}, out, (k < FL) ? frame[k/BC] : 1'b1);
            check({tag, " rfd"}, rfd, (k >= rfd_k));
            if (k + 1 >= hold) dav_ = 1'b1;
            if (scramble) byte_in = '0;
        end
    endtask

    function automatic logic [N+1:0] model_frame(input logic [N-1:0] d);
        logic [N+1:0] f;
        f[0] = 1'b0;
        for (int i = 0; i < N; i++) f[i+1] = d[i];
        f[N+1] = 1'b1;
        return f;
    endfunction

    vec_t tbl[6];

    initial begin
        tbl[0] = '{8'hA5, 1,  1'b0, 10'h34A, 40};
        tbl[1] = '{8'hA5, 50, 1'b0, 10'h34A, 50};
        tbl[2] = '{8'hA5, 1,  1'b1, 10'h34A, 40};
        tbl[3] = '{8'h01, 1,  1'b0, 10'h202, 40};
        tbl[4] = '{8'hFF, 1,  1'b0, 10'h3FE, 40};
        tbl[5] = '{8'h00, 3,  1'b0, 10'h200, 40};

        reset_  = 1'b0;
        dav_    = 1'b1;
        byte_in = '0;
        cycle();
        cycle();
        check("reset rfd", rfd, 1'b1);
        check("reset out", out, 1'b1);
        reset_ = 1'b1;
        cycle();

        // Asynchronous reset during the start bit
        run_frame(8'hA5, 1, 1'b0, 10'h34A, 40, 2, "pre-reset");
        #2 reset_ = 1'b0;
        #1;
        check("async rfd", rfd, 1'b1);
        check("async out", out, 1'b1);
        cycle();
        cycle();
        check("hold rfd", rfd, 1'b1);
        check("hold out", out, 1'b1);
        reset_ = 1'b1;
        cycle();
        check("post-reset idle out", out, 1'b1);

        for (int i = 0; i < 6; i++)
            run_frame(tbl[i].data, tbl[i].hold, tbl[i].scramble, tbl[i].frame,
                      tbl[i].rfd_k, 1000, $sformatf("vec%0d", i));

        // Reset during data bit 3 of 3C, then a clean C3 frame
        run_frame(8'h3C, 1, 1'b0, 10'h278, 40, 17, "abort 3C");
        #2 reset_ = 1'b0;
        #1;
        check("abort rfd", rfd, 1'b1);
        check("abort out", out, 1'b1);
        cycle();
        reset_ = 1'b1;
        run_frame(8'hC3, 1, 1'b0, 10'h386, 40, 1000, "after-abort C3");

        for (int r = 0; r < 20; r++) begin
            logic [N-1:0] d;
            int           h;
            int           gap;
            d   = N'($urandom);
            h   = $urandom_range(1, 55);
            gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) begin
                cycle();
                check("gap out", out, 1'b1);
                check("gap rfd", rfd, 1'b1);
            end
            run_frame(d, h, 1'($urandom_range(0, 1)), model_frame(d), (h > FL) ? h : FL,
                      1000, $sformatf("rnd%0d d=%h h=%0d", r, d, h));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
